// File: rtl/discrete_audio_pkg.sv
// rtl/discrete_audio_pkg.sv - shared widths and tag type for the discrete-audio log path
package discrete_audio_pkg;

  localparam int LOG_IN_W  = 24;
  localparam int LOG_OUT_W = 12;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } log_tag_t;

endpackage

// File: rtl/vco_log_arbiter_rr_pick.sv
// rtl/vco_log_arbiter_rr_pick.sv - combinational round-robin selector (first set bit at or after ptr, wrapping)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant,
  output logic [2:0]   idx,
  output logic         any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // upper segment [ptr..N-1] has priority over the wrapped segment [0..ptr-1]
    for (int c = 0; c < N; c++) begin
      if (!any && mask[c] && (3'(c) >= ptr)) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = 3'(c);
      end
    end
    for (int c = 0; c < N; c++) begin
      if (!any && mask[c] && (3'(c) < ptr)) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = 3'(c);
      end
    end
  end

endmodule

// File: rtl/vco_log_arbiter.sv
// rtl/vco_log_arbiter.sv - round-robin sharing of one pipelined natural_log among VCO channels
// Optional result cache for repeated arguments: define VCO_LOG_ARB_CACHE_EN.
module vco_log_arbiter
  import discrete_audio_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int LOG_LATENCY = 2,
  parameter int IN_W        = LOG_IN_W,
  parameter int OUT_W       = LOG_OUT_W
) (
  input  logic                   clk,
  input  logic                   I_RSTn,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*IN_W-1:0]   arg,
  output logic [N_CH-1:0]        ack,
  output logic [N_CH*OUT_W-1:0]  result,
  output logic [IN_W-1:0]        log_in,
  input  logic [OUT_W-1:0]       log_out
);

  logic [N_CH-1:0]         inflight_q, inflight_d;
  logic [2:0]              ptr_q, ptr_d;
  log_tag_t [LOG_LATENCY:0] tag_q, tag_d;
  logic [IN_W-1:0]         log_in_q, log_in_d;
  logic [N_CH-1:0]         ack_q, ack_d;
  logic [N_CH*OUT_W-1:0]   result_q, result_d;
`ifdef VCO_LOG_ARB_CACHE_EN
  logic [N_CH*IN_W-1:0]    last_arg_q, last_arg_d;
  logic [N_CH*IN_W-1:0]    pend_arg_q, pend_arg_d;
  logic [N_CH-1:0]         cache_ok_q, cache_ok_d;
`endif

  logic [N_CH-1:0] elig, gnt_oh;
  logic [2:0]      gnt_idx;
  logic            gnt_any;
  logic [IN_W-1:0] gnt_arg;
  logic            gnt_hit;

  // a channel stays ineligible through its capture edge because inflight_q clears only then
  assign elig = req & ~inflight_q;

  rr_pick #(.N(N_CH)) u_pick (
    .mask  (elig),
    .ptr   (ptr_q),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    gnt_arg = '0;
    gnt_hit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt_oh[c]) begin
        gnt_arg = arg[c*IN_W +: IN_W];
`ifdef VCO_LOG_ARB_CACHE_EN
        gnt_hit = cache_ok_q[c] && (arg[c*IN_W +: IN_W] == last_arg_q[c*IN_W +: IN_W]);
`endif
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    ptr_d      = ptr_q;
    log_in_d   = log_in_q;
    ack_d      = '0;
    result_d   = result_q;
    tag_d[0]   = '0;
    for (int s = 1; s <= LOG_LATENCY; s++) tag_d[s] = tag_q[s-1];
`ifdef VCO_LOG_ARB_CACHE_EN
    last_arg_d = last_arg_q;
    pend_arg_d = pend_arg_q;
    cache_ok_d = cache_ok_q;
`endif

    for (int c = 0; c < N_CH; c++) begin
      if (tag_q[LOG_LATENCY].valid && (tag_q[LOG_LATENCY].idx == 3'(c))) begin
        result_d[c*OUT_W +: OUT_W] = log_out;
        ack_d[c]      = 1'b1;
        inflight_d[c] = 1'b0;
`ifdef VCO_LOG_ARB_CACHE_EN
        last_arg_d[c*IN_W +: IN_W] = pend_arg_q[c*IN_W +: IN_W];
        cache_ok_d[c] = 1'b1;
`endif
      end
    end

    if (gnt_any) begin
      ptr_d = (gnt_idx == 3'(N_CH-1)) ? 3'd0 : gnt_idx + 3'd1;
      if (gnt_hit) begin
        ack_d = ack_d | gnt_oh;
      end else begin
        log_in_d       = gnt_arg;
        tag_d[0].valid = 1'b1;
        tag_d[0].idx   = gnt_idx;
        inflight_d     = inflight_d | gnt_oh;
`ifdef VCO_LOG_ARB_CACHE_EN
        for (int c = 0; c < N_CH; c++) begin
          if (gnt_oh[c]) pend_arg_d[c*IN_W +: IN_W] = gnt_arg;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      inflight_q <= '0;
      ptr_q      <= '0;
      tag_q      <= '0;
      log_in_q   <= '0;
      ack_q      <= '0;
      result_q   <= '0;
`ifdef VCO_LOG_ARB_CACHE_EN
      last_arg_q <= '0;
      pend_arg_q <= '0;
      cache_ok_q <= '0;
`endif
    end else begin
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      tag_q      <= tag_d;
      log_in_q   <= log_in_d;
      ack_q      <= ack_d;
      result_q   <= result_d;
`ifdef VCO_LOG_ARB_CACHE_EN
      last_arg_q <= last_arg_d;
      pend_arg_q <= pend_arg_d;
      cache_ok_q <= cache_ok_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign result = result_q;
  assign log_in = log_in_q;

endmodule

// File: tb/tb_vco_log_arbiter.sv
// tb/tb_vco_log_arbiter.sv - directed bench for vco_log_arbiter with a two-stage natural_log model
module tb_vco_log_arbiter;

  localparam int N_CH = 4;
  localparam int L    = 2;
  localparam int IW   = 24;
  localparam int OW   = 12;
`ifdef VCO_LOG_ARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_CH-1:0]      req = '0;
  logic [N_CH*IW-1:0]   argv = '0;
  logic [N_CH-1:0]      ack;
  logic [N_CH*OW-1:0]   result;
  logic [IW-1:0]        log_in;
  logic [OW-1:0]        log_out;
  logic [OW-1:0]        lm1 = '0, lm2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vco_log_arbiter #(.N_CH(N_CH), .LOG_LATENCY(L), .IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .I_RSTn(rst_n), .req(req), .arg(argv),
    .ack(ack), .result(result), .log_in(log_in), .log_out(log_out)
  );

  // natural_log stand-in: ln(x/256)*256 truncated for the arguments used here
  function automatic logic [OW-1:0] ln_model(input logic [IW-1:0] a);
    case (a)
      24'h000100: ln_model = 12'h000;
      24'h000180: ln_model = 12'h067;
      24'h000200: ln_model = 12'h0B1;
      24'h000280: ln_model = 12'h0EA;
      24'h000300: ln_model = 12'h119;
      24'h000400: ln_model = 12'h162;
      default:    ln_model = a[15:4] ^ 12'hA5A;
    endcase
  endfunction

  always @(posedge clk) begin
    lm1 <= ln_model(log_in);
    lm2 <= lm1;
  end
  assign log_out = lm2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] res_of(input int ch);
    res_of = result[ch*OW +: OW];
  endfunction

  // one request on one channel; k counts negedges from the drive, so a normal ack lands at k=4
  task automatic run_one(input int ch, input logic [IW-1:0] a, input logic [OW-1:0] exp_res,
                         input int exp_k, input logic [IW-1:0] exp_login);
    int  k;
    bit  got;
    k = 0;
    got = 1'b0;
    argv[ch*IW +: IW] = a;
    req[ch] = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("log_in_after_grant", log_in, exp_login);
      if (ack[ch]) got = 1'b1;
    end
    chk("ack_onehot", ack, 64'(1 << ch));
    req[ch] = 1'b0;
    chk("ack_latency", k, exp_k);
    chk("result", res_of(ch), exp_res);
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
  endtask

  typedef struct {
    int              ch;
    logic [IW-1:0]   a;
    logic [OW-1:0]   res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int first[N_CH];
    int nack[N_CH];
    int a1, a2, k;
    bit saw2;
    logic [IW-1:0] rr_args[N_CH];

    vecs[0] = '{ch: 1, a: 24'h000180, res: 12'h067};
    vecs[1] = '{ch: 0, a: 24'h000200, res: 12'h0B1};
    vecs[2] = '{ch: 2, a: 24'h000300, res: 12'h119};
    vecs[3] = '{ch: 3, a: 24'h000400, res: 12'h162};
    vecs[4] = '{ch: 1, a: 24'h000280, res: 12'h0EA};
    vecs[5] = '{ch: 3, a: 24'h000100, res: 12'h000};

    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 0);
    chk("reset_result", result, 0);
    chk("reset_log_in", log_in, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_one(vecs[i].ch, vecs[i].a, vecs[i].res, 4, vecs[i].a);

    // continuous requester on channel 2
    a1 = 0; a2 = 0; k = 0;
    argv[2*IW +: IW] = 24'h000200;
    req[2] = 1'b1;
    while (a2 == 0 && k < 20) begin
      @(negedge clk);
      k++;
      if (ack[2]) begin
        if (a1 == 0) a1 = k;
        else begin a2 = k; req[2] = 1'b0; end
      end
    end
    req[2] = 1'b0;
    chk("cont_first_ack", a1, 4);
    chk("cont_second_ack", a2, CACHE ? 5 : 8);
    repeat (2) @(negedge clk);

    // all four at once after reset: grants 0..3 on consecutive edges
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_args[0] = 24'h000100; rr_args[1] = 24'h000180;
    rr_args[2] = 24'h000300; rr_args[3] = 24'h000400;
    for (int c = 0; c < N_CH; c++) begin
      argv[c*IW +: IW] = rr_args[c];
      first[c] = 0;
      nack[c] = 0;
    end
    req = 4'hF;
    for (int kk = 1; kk <= 12; kk++) begin
      @(negedge clk);
      if (kk <= 4) chk("rr_log_in_order", log_in, rr_args[kk-1]);
      for (int c = 0; c < N_CH; c++) begin
        if (ack[c]) begin
          nack[c]++;
          if (first[c] == 0) first[c] = kk;
          req[c] = 1'b0;
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      chk("rr_ack_time", first[c], 4 + c);
      chk("rr_ack_count", nack[c], 1);
      chk("rr_result", res_of(c), ln_model(rr_args[c]));
    end

    // reset with channel 2 in flight; ptr would otherwise point at 3
    argv[2*IW +: IW] = 24'h000200;
    req = 4'b0100;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("midreset_ack", ack, 0);
    chk("midreset_result", result, 0);
    chk("midreset_log_in", log_in, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    argv[0*IW +: IW] = 24'h000280;
    argv[3*IW +: IW] = 24'h000300;
    req = 4'b1001;
    first[0] = 0; first[3] = 0; saw2 = 1'b0;
    for (int kk = 1; kk <= 10; kk++) begin
      @(negedge clk);
      if (kk == 1) chk("postreset_first_grant", log_in, 24'h000280);
      if (ack[2]) saw2 = 1'b1;
      if (ack[0] && first[0] == 0) begin first[0] = kk; req[0] = 1'b0; end
      if (ack[3] && first[3] == 0) begin first[3] = kk; req[3] = 1'b0; end
    end
    chk("postreset_no_ack2", saw2, 0);
    chk("postreset_ack0_time", first[0], 4);
    chk("postreset_ack3_time", first[3], 5);
    chk("postreset_result0", res_of(0), 12'h0EA);
    chk("postreset_result3", res_of(3), 12'h119);

    // drop req while in flight, change arg while in flight
    argv[0*IW +: IW] = 24'h000200;
    argv[3*IW +: IW] = 24'h000180;
    req = 4'b1001;
    first[0] = 0; first[3] = 0;
    for (int kk = 1; kk <= 10; kk++) begin
      @(negedge clk);
      if (kk == 1) req[0] = 1'b0;
      if (kk == 2) argv[3*IW +: IW] = 24'h000400;
      if (ack[0] && first[0] == 0) first[0] = kk;
      if (ack[3] && first[3] == 0) begin first[3] = kk; req[3] = 1'b0; end
    end
    req = '0;
    chk("dropped_ack0_time", first[0], 4);
    chk("dropped_result0", res_of(0), 12'h0B1);
    chk("argchg_ack3_time", first[3], 5);
    chk("argchg_result3", res_of(3), 12'h067);

    // repeated argument on channel 1, with another issue in between so log_in differs
    run_one(1, 24'h000180, 12'h067, 4, 24'h000180);
    run_one(2, 24'h000300, 12'h119, 4, 24'h000300);
    run_one(1, 24'h000180, 12'h067, CACHE ? 1 : 4, CACHE ? 24'h000300 : 24'h000180);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
